johnson_slot_arbiter: RTL and testbench
=======================================

JOHNSON_SLOT_ARBITER -- requirements
Module: johnson_slot_arbiter

Interface
REQ-001 SHALL have parameter: MAX_HOLD, 4, maximum consecutive grant cycles per slot (legal 1..15).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: en  input  1  arbitration enable.
REQ-005 SHALL have port: req  input  8  per-requester request, bit i = requester i.
REQ-006 SHALL have port: ld  input  1  load Johnson slot register (honoured in IDLE only).
REQ-007 SHALL have port: ld_val  input  4  value loaded on ld (any pattern, including illegal).
REQ-008 SHALL have port: gnt  output  8  registered grant, one-hot or zero.
REQ-009 SHALL have port: js  output  4  current Johnson slot register.
REQ-010 SHALL have port: slot  output  3  decoded slot index of js (0 for illegal patterns).
REQ-011 SHALL have port: busy  output  1  high when FSM is not IDLE.
REQ-012 SHALL have port: err  output  1  one-cycle pulse on illegal js detection.

Function
REQ-013 SHALL hold a 4-bit Johnson register; advance = {~js[0], js[3:1]}.
REQ-014 SHALL decode slot: 0000->0, 1000->1, 1100->2, 1110->3, 1111->4, 0111->5, 0011->6, 0001->7; the other 8 patterns are illegal.
REQ-015 SHALL implement FSM states IDLE, SCAN, GRANT; all transitions on the rising clk edge.
REQ-016 IDLE: gnt=0, js holds; ld=1 loads ld_val; en=1 moves to SCAN (ld and en in the same cycle: load applies and SCAN is entered on the same edge).
REQ-017 SCAN, js illegal: err=1 next cycle for exactly one cycle, js<=0000, no grant, remain in SCAN.
REQ-018 SCAN, js legal, en=0: move to IDLE, js holds.
REQ-019 SCAN, en=1, req[slot]=1: next cycle GRANT, gnt=one-hot(slot), hold count=1, js holds.
REQ-020 SCAN, en=1, req[slot]=0: js advances one step, remain in SCAN; an empty slot costs exactly one cycle.
REQ-021 GRANT, req[owner]=0 or hold count==MAX_HOLD: next cycle gnt=0, js advances, state becomes SCAN (IDLE if en=0).
REQ-022 GRANT, otherwise: hold count increments; gnt stays unchanged.
REQ-023 SHALL never preempt a grant: en=0 during GRANT takes effect only at release.
REQ-024 SHALL ignore ld outside IDLE; SHALL ignore req bits of non-current slots.
REQ-025 Grant high time per slot SHALL be 1..MAX_HOLD cycles; gnt SHALL never have more than one bit set.
REQ-026 With all requesters continuously requesting, service order SHALL be 0,1,...,7,0 (strict slot rotation).

Reset
REQ-027 On rst=1 at a clk edge: state=IDLE, js=0000, gnt=0, hold count=0, err=0, busy=0, slot=0.
REQ-028 rst SHALL override en, ld and any in-progress grant, including mid-GRANT.

Verification
REQ-029 Reset, en=1, req=0 for 10 cycles -> js walks 0000,1000,1100,1110,1111,0111,0011,0001,0000,1000; slot 0..7,0,1; gnt=0.
REQ-030 Reset, en=1, req=8'h01 constant, MAX_HOLD=4 -> gnt=8'h01 for 4 cycles, then 0 for 8 cycles, repeating (period 12).
REQ-031 SCAN reaches slot 2 with req=8'h04; req[2] drops after 2 grant cycles -> gnt=0 the following cycle, js advances to 1110.
REQ-032 In IDLE: ld=1, ld_val=4'b1010, then en=1 -> err=1 for one cycle, js=0000, slot=0, normal scanning resumes.
REQ-033 en dropped in the first GRANT cycle with req held -> gnt stays high for MAX_HOLD cycles, then IDLE, busy=0, js holds its advanced value.
REQ-034 rst asserted mid-GRANT -> next cycle gnt=0, js=0000, busy=0; no grant until en=1 again.

Source files
------------

// File: rtl/johnson_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : johnson_slot_arbiter
// Brief   : Time-slot arbiter over 8 requesters; a 4-bit Johnson register
//           selects the current slot, a grant is held up to MAX_HOLD cycles.
// Rev     : 1.0  initial release
// ============================================================================
module johnson_slot_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       ld,
  input  logic [3:0] ld_val,
  output logic [7:0] gnt,
  output logic [3:0] js,
  output logic [2:0] slot,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_GRANT = 2'd2
  } state_t;

  localparam logic [3:0] c_max_hold = 4'(MAX_HOLD);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_js, w_js_nxt;
  logic [7:0] r_gnt, w_gnt_nxt;
  logic [3:0] r_hold, w_hold_nxt;
  logic       r_err, w_err_nxt;

  logic [2:0] w_slot;
  logic       w_legal;
  logic [3:0] w_js_adv;

  assign w_js_adv = {~r_js[0], r_js[3:1]};

  always_comb begin
    w_slot  = 3'd0;
    w_legal = 1'b1;
    case (r_js)
      4'b0000: w_slot = 3'd0;
      4'b1000: w_slot = 3'd1;
      4'b1100: w_slot = 3'd2;
      4'b1110: w_slot = 3'd3;
      4'b1111: w_slot = 3'd4;
      4'b0111: w_slot = 3'd5;
      4'b0011: w_slot = 3'd6;
      4'b0001: w_slot = 3'd7;
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_js    <= 4'b0000;
      r_gnt   <= 8'h00;
      r_hold  <= 4'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_js    <= w_js_nxt;
      r_gnt   <= w_gnt_nxt;
      r_hold  <= w_hold_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_js_nxt    = r_js;
    w_gnt_nxt   = r_gnt;
    w_hold_nxt  = r_hold;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_gnt_nxt = 8'h00;
        if (ld) w_js_nxt = ld_val;
        if (en) w_state_nxt = S_SCAN;
      end
      S_SCAN: begin
        // A corrupted slot register is repaired before anything else is considered.
        if (!w_legal) begin
          w_err_nxt = 1'b1;
          w_js_nxt  = 4'b0000;
        end else if (!en) begin
          w_state_nxt = S_IDLE;
        end else if (req[w_slot]) begin
          w_state_nxt = S_GRANT;
          w_gnt_nxt   = 8'h01 << w_slot;
          w_hold_nxt  = 4'd1;
        end else begin
          w_js_nxt = w_js_adv;
        end
      end
      S_GRANT: begin
        // The owner is the current slot since js is frozen while granting.
        if (!req[w_slot] || (r_hold == c_max_hold)) begin
          w_gnt_nxt   = 8'h00;
          w_js_nxt    = w_js_adv;
          w_state_nxt = en ? S_SCAN : S_IDLE;
        end else begin
          w_hold_nxt = r_hold + 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = 8'h00;
      end
    endcase
  end

  assign gnt  = r_gnt;
  assign js   = r_js;
  assign slot = w_slot;
  assign busy = (r_state != S_IDLE);
  assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_johnson_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_johnson_slot_arbiter
// Brief   : Directed and randomized checks of johnson_slot_arbiter against a
//           slot-index reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_johnson_slot_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [7:0] req = 8'h00;
  logic       ld = 1'b0;
  logic [3:0] ld_val = 4'h0;
  logic [7:0] gnt;
  logic [3:0] js;
  logic [2:0] slot;
  logic       busy;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  johnson_slot_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .ld(ld), .ld_val(ld_val),
    .gnt(gnt), .js(js), .slot(slot), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Slot index -> register pattern, straight from the slot table.
  logic [3:0] js_tab [8];
  initial begin
    js_tab[0] = 4'b0000; js_tab[1] = 4'b1000; js_tab[2] = 4'b1100; js_tab[3] = 4'b1110;
    js_tab[4] = 4'b1111; js_tab[5] = 4'b0111; js_tab[6] = 4'b0011; js_tab[7] = 4'b0001;
  end

  // Model: mode 0=idle 1=scan 2=grant; slot kept as an integer index.
  int         m_mode = 0;
  int         m_slot = 0;
  int         m_hold = 0;
  bit         m_legal = 1'b1;
  logic [3:0] m_raw = 4'h0;
  logic [7:0] m_gnt = 8'h00;
  bit         m_err = 1'b0;
  bit         m_valid = 1'b0;

  always @(posedge clk) begin
    logic [3:0] exp_js;
    logic [2:0] exp_slot;
    if (rst) begin
      m_mode = 0; m_slot = 0; m_hold = 0; m_legal = 1'b1;
      m_gnt = 8'h00; m_err = 1'b0; m_valid = 1'b1;
    end else begin
      m_err = 1'b0;
      case (m_mode)
        0: begin
          m_gnt = 8'h00;
          if (ld) begin
            m_raw = ld_val;
            m_legal = 1'b0;
            for (int i = 0; i < 8; i++)
              if (js_tab[i] == ld_val) begin m_legal = 1'b1; m_slot = i; end
          end
          if (en) m_mode = 1;
        end
        1: begin
          if (!m_legal) begin
            m_err = 1'b1; m_legal = 1'b1; m_slot = 0;
          end else if (!en) begin
            m_mode = 0;
          end else if (req[m_slot]) begin
            m_mode = 2; m_gnt = 8'h00; m_gnt[m_slot] = 1'b1; m_hold = 1;
          end else begin
            m_slot = (m_slot + 1) % 8;
          end
        end
        default: begin
          if (!req[m_slot] || m_hold == MAX_HOLD) begin
            m_gnt = 8'h00; m_slot = (m_slot + 1) % 8; m_mode = en ? 1 : 0;
          end else begin
            m_hold = m_hold + 1;
          end
        end
      endcase
    end
    #1;
    if (m_valid) begin
      exp_js   = m_legal ? js_tab[m_slot] : m_raw;
      exp_slot = m_legal ? 3'(m_slot) : 3'd0;
      n_checks++;
      if (gnt !== m_gnt || js !== exp_js || slot !== exp_slot ||
          busy !== (m_mode != 0) || err !== m_err) begin
        n_fail++;
        $display("FAIL model t=%0t: gnt=%h js=%b slot=%0d busy=%b err=%b, required gnt=%h js=%b slot=%0d busy=%b err=%b",
                 $time, gnt, js, slot, busy, err, m_gnt, exp_js, exp_slot, (m_mode != 0), m_err);
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, expv);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; req = 8'h00; ld = 1'b0; ld_val = 4'h0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] walk [10];
    walk[0] = 4'b0000; walk[1] = 4'b1000; walk[2] = 4'b1100; walk[3] = 4'b1110;
    walk[4] = 4'b1111; walk[5] = 4'b0111; walk[6] = 4'b0011; walk[7] = 4'b0001;
    walk[8] = 4'b0000; walk[9] = 4'b1000;

    // Reset values
    do_reset();
    check("reset_gnt", gnt, 8'h00);
    check("reset_js", {4'h0, js}, 8'h00);
    check("reset_busy", {7'h0, busy}, 8'h00);
    check("reset_err", {7'h0, err}, 8'h00);

    // Empty-slot walk
    en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("walk_js", {4'h0, js}, {4'h0, walk[k]});
      check("walk_slot", {5'h0, slot}, 8'(k % 8));
      check("walk_gnt", gnt, 8'h00);
    end

    // Single constant requester: 4 on, 8 off
    do_reset();
    en = 1'b1; req = 8'h01;
    @(negedge clk);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      check("period12_gnt", gnt, ((k % 12) < 4) ? 8'h01 : 8'h00);
    end

    // Early release at slot 2
    do_reset();
    en = 1'b1; req = 8'h04;
    repeat (4) @(negedge clk);
    check("slot2_gnt1", gnt, 8'h04);
    @(negedge clk);
    check("slot2_gnt2", gnt, 8'h04);
    req = 8'h00;
    @(negedge clk);
    check("slot2_release", gnt, 8'h00);
    check("slot2_js", {4'h0, js}, 8'h0E);

    // Illegal load recovery
    do_reset();
    ld = 1'b1; ld_val = 4'b1010;
    @(negedge clk);
    check("ld_js", {4'h0, js}, 8'h0A);
    check("ld_slot", {5'h0, slot}, 8'h00);
    ld = 1'b0; en = 1'b1;
    @(negedge clk);
    check("ill_busy", {7'h0, busy}, 8'h01);
    check("ill_err_pre", {7'h0, err}, 8'h00);
    @(negedge clk);
    check("ill_err", {7'h0, err}, 8'h01);
    check("ill_js", {4'h0, js}, 8'h00);
    @(negedge clk);
    check("ill_err_clr", {7'h0, err}, 8'h00);
    check("ill_resume_js", {4'h0, js}, 8'h08);
    check("ill_resume_slot", {5'h0, slot}, 8'h01);

    // en dropped during the first grant cycle
    do_reset();
    en = 1'b1; req = 8'h01;
    repeat (2) @(negedge clk);
    check("nopre_gnt0", gnt, 8'h01);
    en = 1'b0;
    for (int k = 0; k < MAX_HOLD - 1; k++) begin
      @(negedge clk);
      check("nopre_gnt", gnt, 8'h01);
    end
    @(negedge clk);
    check("nopre_rel", gnt, 8'h00);
    check("nopre_busy", {7'h0, busy}, 8'h00);
    check("nopre_js", {4'h0, js}, 8'h08);
    @(negedge clk);
    check("nopre_js_hold", {4'h0, js}, 8'h08);

    // Reset mid-grant
    do_reset();
    en = 1'b1; req = 8'hFF;
    repeat (2) @(negedge clk);
    check("midrst_gnt", gnt, 8'h01);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_gnt0", gnt, 8'h00);
    check("midrst_js", {4'h0, js}, 8'h00);
    check("midrst_busy", {7'h0, busy}, 8'h00);
    rst = 1'b0; en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("midrst_idle_gnt", gnt, 8'h00);
      check("midrst_idle_busy", {7'h0, busy}, 8'h00);
    end

    // Randomized traffic, checked by the model every cycle
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      rst    = ($urandom_range(0, 199) == 0);
      en     = ($urandom_range(0, 9) < 8);
      req    = 8'($urandom) & 8'($urandom);
      ld     = ($urandom_range(0, 9) == 0);
      ld_val = 4'($urandom);
    end
    @(negedge clk);
    rst = 1'b0; en = 1'b0; ld = 1'b0; req = 8'h00;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
